// File: rtl/usb_link_pkg.sv
// usb_link_pkg: constants, FSM state encoding and check-byte helper shared by the USB port link.
package usb_link_pkg;
    localparam logic [7:0] TX_HEAD      = 8'hA5;
    localparam logic [7:0] RX_HEAD      = 8'h5A;
    localparam int         PKT_LEN      = 6;
    localparam logic [3:0] ERR_TYPE_DEF = 4'hF;

    typedef enum logic [2:0] {IDLE, TX, SEND_DONE, RX_WAIT, RX, READ} state_t;

    function automatic logic [7:0] pkt_check(input logic [7:0] b1, b2, b3, b4);
        return b1 ^ b2 ^ b3 ^ b4;
    endfunction
endpackage

// File: rtl/usb_port_link_if.sv
// usb_port_link_if: branch handshake plus byte-stream PHY signals of one device slot.
interface usb_port_link_if;
    logic        fs_send, fd_send;
    logic [3:0]  send_btype, device_idx, data_idx;
    logic [15:0] conf_cmd;
    logic        fs_read, fd_read;
    logic [3:0]  read_btype;
    logic [7:0]  tx_data;
    logic        tx_vld, tx_rdy;
    logic [7:0]  rx_data;
    logic        rx_vld;

    modport master (
        output fs_send, send_btype, device_idx, data_idx, conf_cmd, fd_read, tx_rdy, rx_data, rx_vld,
        input  fd_send, fs_read, read_btype, tx_data, tx_vld
    );
    modport slave (
        input  fs_send, send_btype, device_idx, data_idx, conf_cmd, fd_read, tx_rdy, rx_data, rx_vld,
        output fd_send, fs_read, read_btype, tx_data, tx_vld
    );
endinterface

// File: rtl/usb_link_tx_ser.sv
// usb_link_tx_ser: 6-byte command packet serializer with valid/ready stall.
module usb_link_tx_ser import usb_link_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       tx_rdy,
    input  logic [7:0] b1,
    input  logic [7:0] b2,
    input  logic [7:0] b3,
    input  logic [7:0] b4,
    output logic [7:0] tx_data,
    output logic       tx_vld,
    output logic       done
);
    logic [7:0] pkt [PKT_LEN];
    logic [2:0] idx;
    logic       busy;

    assign done    = busy && tx_rdy && idx == 3'(PKT_LEN - 1);
    assign tx_vld  = busy;
    assign tx_data = busy ? pkt[idx] : '0;

    // whole packet is frozen at load so stalls never see the branch inputs change
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            busy <= 1'b0;
            idx  <= '0;
            for (int i = 0; i < PKT_LEN; i++) pkt[i] <= '0;
        end else if (load) begin
            busy <= 1'b1;
            idx  <= '0;
            pkt  <= '{TX_HEAD, b1, b2, b3, b4, pkt_check(b1, b2, b3, b4)};
        end else if (busy && tx_rdy) begin
            busy <= !done;
            idx  <= done ? '0 : idx + 3'd1;
        end
endmodule

// File: rtl/usb_port_link.sv
// usb_port_link: per-slot USB link; sends a 6-byte command packet, then returns the btype
// of the device's validated 3-byte reply, or ERR_TYPE if none arrives in time.
module usb_port_link import usb_link_pkg::*; #(
    parameter logic [15:0] TIMEOUT  = 16'd50000,
    parameter logic [3:0]  ERR_TYPE = ERR_TYPE_DEF
) (
    input logic            clk,
    input logic            rst,
    usb_port_link_if.slave bus
);
    state_t      state, nxt;
    logic        fs_send_q, start, done, hdr, last, accept, tmo, waiting, have_r1;
    logic        ser_vld;
    logic [7:0]  ser_data, r1;
    logic [15:0] cnt;
    logic [3:0]  btype_q;

    assign start   = state == IDLE && bus.fs_send && !fs_send_q;
    assign waiting = state == RX_WAIT || state == RX;
    assign tmo     = waiting && cnt >= TIMEOUT - 16'd1;
    assign hdr     = bus.rx_vld && bus.rx_data == RX_HEAD;
    assign last    = state == RX && bus.rx_vld && have_r1;
    assign accept  = last && r1[7:4] == bus.device_idx && bus.rx_data == r1;

    usb_link_tx_ser u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (start),
        .tx_rdy  (bus.tx_rdy),
        .b1      ({bus.device_idx, bus.send_btype}),
        .b2      ({bus.data_idx, 4'h0}),
        .b3      (bus.conf_cmd[15:8]),
        .b4      (bus.conf_cmd[7:0]),
        .tx_data (ser_data),
        .tx_vld  (ser_vld),
        .done    (done)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start ? TX : IDLE;
            TX:        nxt = done ? SEND_DONE : TX;
            SEND_DONE: nxt = bus.fs_send ? SEND_DONE : RX_WAIT;
            RX_WAIT:   nxt = tmo ? READ : hdr ? RX : RX_WAIT;
            RX:        nxt = (accept || tmo) ? READ : last ? RX_WAIT : RX;
            READ:      nxt = bus.fd_read ? IDLE : READ;
            default:   nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.fd_send    = state == SEND_DONE;
        bus.fs_read    = state == READ;
        bus.read_btype = btype_q;
        bus.tx_data    = ser_data;
        bus.tx_vld     = ser_vld;
    end

    // timeout keeps running across a rejected reply; it only restarts when fd_send drops
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fs_send_q <= 1'b0;
            cnt       <= '0;
            have_r1   <= 1'b0;
            r1        <= '0;
            btype_q   <= '0;
        end else begin
            fs_send_q <= bus.fs_send;
            cnt       <= state == SEND_DONE ? '0 : (waiting && cnt != '1) ? cnt + 16'd1 : cnt;
            have_r1   <= state == RX && (bus.rx_vld ? !have_r1 : have_r1);
            if (state == RX && bus.rx_vld && !have_r1) r1 <= bus.rx_data;
            if (accept)   btype_q <= r1[3:0];
            else if (tmo) btype_q <= ERR_TYPE;
        end
endmodule
